// File: rtl/conv_32_8.sv
// 32-bit to 8-bit width down-converter with a one-word pending buffer (byte-rate clock).
// Optional sticky overrun flag output `ovf` enabled by defining CONV_32_8_OVF_EN.
module conv_32_8 #(
  parameter bit         MSB_FIRST = 1'b1,
  parameter logic [7:0] IDLE_DATA = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in32,
  input  logic [31:0] in_data32,
  output logic        ready32,
  output logic        out8,
  output logic [7:0]  out_data8
`ifdef CONV_32_8_OVF_EN
  ,
  output logic        ovf
`endif
);

  typedef enum logic {StIdle, StSend} state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] shreg_q, shreg_d;
  logic [31:0] pend_q, pend_d;
  logic        pend_v_q, pend_v_d;
  logic        out8_q, out8_d;
  logic [7:0]  out_data8_q, out_data8_d;
  logic        accept;

  function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [1:0] pos;
    pos = MSB_FIRST ? (2'd3 - idx) : idx;
    unique case (pos)
      2'd0:    sel_byte = word[7:0];
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      default: sel_byte = word[31:24];
    endcase
  endfunction

  assign ready32 = reset & ~pend_v_q;
  assign accept  = in32 & ready32;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          shreg_d = in_data32;
          idx_d   = 2'd0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (idx_q == 2'd3) begin
          // Pending word wins; ready32 is low whenever it is present, so no accept can collide.
          if (pend_v_q) begin
            shreg_d  = pend_q;
            pend_v_d = 1'b0;
            idx_d    = 2'd0;
          end else if (accept) begin
            shreg_d = in_data32;
            idx_d   = 2'd0;
          end else begin
            idx_d   = 2'd0;
            state_d = StIdle;
          end
        end else begin
          idx_d = idx_q + 2'd1;
          if (accept) begin
            pend_d   = in_data32;
            pend_v_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Outputs are registered from next state so the first byte shows one cycle after accept.
    out8_d      = (state_d == StSend);
    out_data8_d = out8_d ? sel_byte(shreg_d, idx_d) : IDLE_DATA;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      idx_q       <= 2'd0;
      shreg_q     <= 32'h0;
      pend_q      <= 32'h0;
      pend_v_q    <= 1'b0;
      out8_q      <= 1'b0;
      out_data8_q <= IDLE_DATA;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      pend_q      <= pend_d;
      pend_v_q    <= pend_v_d;
      out8_q      <= out8_d;
      out_data8_q <= out_data8_d;
    end
  end

  assign out8      = out8_q;
  assign out_data8 = out_data8_q;

`ifdef CONV_32_8_OVF_EN
  logic ovf_q, ovf_d;

  assign ovf_d = ovf_q | (in32 & ~ready32);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_conv_32_8.sv
// Scoreboard bench for conv_32_8: one MSB-first and one LSB-first instance share stimulus.
module tb_conv_32_8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in32 = 1'b0;
  logic [31:0] in_data32 = 32'h0;
  logic        ready32, out8, ready_b, out8_b;
  logic [7:0]  out_data8, data_b;
`ifdef CONV_32_8_OVF_EN
  logic        ovf, ovf_b;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic [7:0]  exp0, exp1;

  always #5 clk = ~clk;

  conv_32_8 #(.MSB_FIRST(1'b1), .IDLE_DATA(8'h00)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in32      (in32),
    .in_data32 (in_data32),
    .ready32   (ready32),
    .out8      (out8),
    .out_data8 (out_data8)
`ifdef CONV_32_8_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  conv_32_8 #(.MSB_FIRST(1'b0), .IDLE_DATA(8'h00)) u_dut_lsb (
    .clk       (clk),
    .reset     (reset),
    .in32      (in32),
    .in_data32 (in_data32),
    .ready32   (ready_b),
    .out8      (out8_b),
    .out_data8 (data_b)
`ifdef CONV_32_8_OVF_EN
    ,
    .ovf       (ovf_b)
`endif
  );

  // Output monitor: every valid byte must match the head of its queue.
  always @(negedge clk) begin
    checks++;
    if (out8) begin
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL sb_msb: unexpected byte %h, required no output", out_data8);
      end else begin
        exp0 = q0.pop_front();
        if (out_data8 !== exp0) begin
          errors++;
          $display("FAIL sb_msb: got %h, required %h", out_data8, exp0);
        end
      end
    end else if (out_data8 !== 8'h00) begin
      errors++;
      $display("FAIL idle_data: got %h, required 00", out_data8);
    end
    checks++;
    if (out8_b) begin
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL sb_lsb: unexpected byte %h, required no output", data_b);
      end else begin
        exp1 = q1.pop_front();
        if (data_b !== exp1) begin
          errors++;
          $display("FAIL sb_lsb: got %h, required %h", data_b, exp1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      q0.push_back(w[31-8*i -: 8]);
      q1.push_back(w[8*i +: 8]);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d/%0d bytes left, required 0", name, q0.size(), q1.size());
    end
    @(negedge clk);
    checks++;
    if (out8 !== 1'b0) begin
      errors++;
      $display("FAIL %s_end_idle: out8 %b, required 0", name, out8);
    end
  endtask

  task automatic send_single(input logic [31:0] w, input string name);
    tick();
    in32      = 1'b1;
    in_data32 = w;
    push_word(w);
    tick();
    in32      = 1'b0;
    in_data32 = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out8 !== 1'b1 || out8_b !== 1'b1) begin
        errors++;
        $display("FAIL %s_valid[%0d]: out8 %b/%b, required 1/1", name, i, out8, out8_b);
      end
    end
    wait_drain(name);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out8 !== 1'b0 || out_data8 !== 8'h00 || ready32 !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: out8 %b data %h ready %b, required 0 00 0",
               out8, out_data8, ready32);
    end
    tick();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (ready32 !== 1'b1 || out8 !== 1'b0 || out_data8 !== 8'h00) begin
      errors++;
      $display("FAIL reset_release: ready %b out8 %b data %h, required 1 0 00",
               ready32, out8, out_data8);
    end
`ifdef CONV_32_8_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b, required 0", ovf);
    end
`endif
  endtask

  task automatic test_single();
    send_single(32'h0F0D0300, "single");
  endtask

  task automatic test_back_to_back();
    logic exp_rdy;
    tick();
    in32      = 1'b1;
    in_data32 = 32'hAABBCCDD;
    push_word(32'hAABBCCDD);
    tick();
    in_data32 = 32'h11223344;
    push_word(32'h11223344);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_rdy = (i == 0 || i >= 4);
      checks++;
      if (out8 !== 1'b1) begin
        errors++;
        $display("FAIL b2b_gap[%0d]: out8 %b, required 1", i, out8);
      end
      checks++;
      if (ready32 !== exp_rdy) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got %b, required %b", i, ready32, exp_rdy);
      end
      if (i == 0) begin
        tick();
        in32      = 1'b0;
        in_data32 = 32'h0;
      end
    end
    @(negedge clk);
    checks++;
    if (out8 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop: out8 %b, required 0", out8);
    end
    wait_drain("b2b");
  endtask

  task automatic test_overrun();
    tick();
    in32      = 1'b1;
    in_data32 = 32'hC0FFEE01;
    push_word(32'hC0FFEE01);
    tick();
    in_data32 = 32'h5A5AA5A5;
    push_word(32'h5A5AA5A5);
    tick();
    in_data32 = 32'hBADBAD00;  // dropped: pending buffer is full
    tick();
    in32      = 1'b0;
    in_data32 = 32'h0;
    @(negedge clk);
    checks++;
    if (ready32 !== 1'b0) begin
      errors++;
      $display("FAIL ovr_ready: got %b, required 0", ready32);
    end
`ifdef CONV_32_8_OVF_EN
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovr_flag: got %b, required 1", ovf);
    end
`endif
    wait_drain("ovr");
`ifdef CONV_32_8_OVF_EN
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovr_sticky: got %b, required 1", ovf);
    end
`endif
  endtask

  task automatic test_lsb_first();
    send_single(32'h01020304, "lsb");
  endtask

  task automatic test_reset_mid_word();
    tick();
    in32      = 1'b1;
    in_data32 = 32'hDEADBEEF;
    push_word(32'hDEADBEEF);
    tick();
    in32      = 1'b0;
    in_data32 = 32'h0;
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out8 !== 1'b0 || out_data8 !== 8'h00 || ready32 !== 1'b0 || out8_b !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: out8 %b data %h ready %b out8_b %b, required 0 00 0 0",
               out8, out_data8, ready32, out8_b);
    end
    checks++;
    if (q0.size() != 2) begin
      errors++;
      $display("FAIL midrst_sent: %0d bytes unsent, required 2", q0.size());
    end
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
`ifdef CONV_32_8_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ovf: got %b, required 0", ovf);
    end
`endif
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out8 !== 1'b0 || ready32 !== 1'b1) begin
        errors++;
        $display("FAIL midrst_quiet[%0d]: out8 %b ready %b, required 0 1", i, out8, ready32);
      end
    end
    send_single(32'h12345678, "midrst_new");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_lsb_first();
    test_reset_mid_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_32_8.md
Name: conv_32_8

Overview:
- Width down-converter: accepts 32-bit parallel words and emits them as four consecutive 8-bit beats with a valid strobe.
- Counterpart to the 8→32 packer on the same link: the 8_32 path rebuilds words from bytes, and this block produces those byte streams from words.
- Runs entirely in the byte-rate domain (4f clock), so one 32-bit word takes 4 cycles to drain.
- A one-word pending buffer lets upstream deliver the next word while the current one is being sent.

Parameters:
- MSB_FIRST, 1: 1 = bits [31:24] are sent first; 0 = bits [7:0] are sent first.
- IDLE_DATA, 8'h00: value driven on out_data8 whenever out8 = 0.

Ports:
- clk  input  1  single clock, 4f byte-rate; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in32  input  1  input word valid.
- in_data32  input  32  input word.
- ready32  output  1  block can accept a word this cycle.
- out8  output  1  output byte valid.
- out_data8  output  8  output byte.

Behaviour:
- Reset value of every output while reset = 0:
  - out8 = 0.
  - out_data8 = IDLE_DATA.
  - ready32 = 0.
  - Internal state: FSM = IDLE, byte index = 0, pending buffer empty.
- ready32 = reset & ~pend_v (combinational from the registered pending-valid bit). It is 1 in the first cycle after reset release.
- Accept rule: a word is captured at a rising edge where in32 = 1 and ready32 = 1. When in32 = 1 and ready32 = 0, the word is ignored (no capture, no side effect).
- FSM states:
  - IDLE: out8 = 0. On accept, load the shift register, set idx = 0, go to SEND.
  - SEND: out8 = 1 and out_data8 = the byte selected by idx (order set by MSB_FIRST); idx increments each cycle.
- At idx = 3 (last byte), in priority order:
  1. If pend_v = 1: move the pending word into the shift register, clear pend_v, set idx = 0, stay in SEND.
  2. Else if an accept occurs this cycle: load the input word directly into the shift register, set idx = 0, stay in SEND.
  3. Else: go to IDLE.
- While in SEND with idx < 3: an accept writes the pending buffer and sets pend_v.
- Latency: the first byte is on out_data8 exactly 1 cycle after the accepting edge. Outputs are registered.
- Throughput: sustained input with one accept every 4 cycles gives an unbroken out8 = 1 stream with no gap cycles between words.
- Backpressure: ready32 drops the cycle after the pending buffer fills. It rises the cycle after the pending word moves into the shift register.
- Accept in the same cycle the pending buffer drains: not possible, because ready32 = 0 in that cycle.
- Reset asserted mid-word: the partially sent word and the pending word are discarded immediately (asynchronous), and outputs go to reset values. After release, transfer restarts cleanly from IDLE.
- X on in_data32 is only propagated when in32 = 1 and the word is accepted.

Optional Feature:
- Macro: CONV_32_8_OVF_EN.
- Defined: adds output port ovf (1 bit). ovf is a sticky flag set at the first rising edge where in32 = 1 and ready32 = 0 (dropped word). It is cleared only by reset, and its reset value is 0.
- Undefined: no ovf port; dropped words are silently ignored and there is no extra logic.

Test Plan:
- Reset low 2 cycles, release → ready32 = 1, out8 = 0, out_data8 = 8'h00.
- Single word 32'h0F0D0300 accepted, MSB_FIRST = 1 → out8 = 1 for 4 cycles starting 1 cycle later, with out_data8 = 0F, 0D, 03, 00; then out8 = 0.
- Back-to-back: hold in32 = 1 with 32'hAABBCCDD then 32'h11223344 → 8 contiguous valid bytes AA BB CC DD 11 22 33 44; ready32 is low for 3 cycles during the first word.
- Overrun: present a third word while pending is full → it is not sent and the output stream is unchanged; with CONV_32_8_OVF_EN defined, ovf = 1 from the next cycle until reset.
- MSB_FIRST = 0, word 32'h01020304 → bytes 04, 03, 02, 01.
- Reset driven low after the second byte of 32'hDEADBEEF → out8 = 0 immediately; after release the remaining bytes never appear, and a new word 32'h12345678 sends 12 34 56 78.
